// File: rtl/drive_frame_streamer.sv
// ============================================================================
//  Module      : drive_frame_streamer
//  Description : Streams one drive frame per START: reads DEPTH packed
//                phase/intensity words from BRAM and emits them expanded to
//                16 bits as a single gap-free burst.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drive_frame_streamer #(
  parameter int DEPTH      = 249,
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              force_zero_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [15:0]       bram_dout_i,
  output logic              dout_valid_o,
  output logic              dout_first_o,
  output logic [15:0]       intensity_out_o,
  output logic [15:0]       phase_out_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              overrun_sticky_o
);

  localparam int                CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_K = CNT_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fz_q, fz_d;

  logic              issue;
  logic              issue_first;
  logic              issue_last;
  logic              start_reject;
  logic              bram_vld;

  // Side-band tags travel alongside each read so the output stage knows
  // which BRAM word is valid, which is sample 0 and which closes the frame.
  logic [RD_LATENCY-1:0] vld_pipe_q;
  logic [RD_LATENCY-1:0] first_pipe_q;
  logic [RD_LATENCY-1:0] last_pipe_q;

  logic              dout_valid_q;
  logic              dout_first_q;
  logic              dout_last_q;
  logic [15:0]       intensity_q;
  logic [15:0]       phase_q;
  logic              overrun_q;
  logic              sticky_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      fz_q    <= fz_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    fz_d    = fz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          base_d  = base_addr_i;
          fz_d    = force_zero_i;
        end
      end
      S_FETCH: begin
        if (cnt_q == LAST_K) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dout_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bram_en_o   = 1'b0;
    bram_addr_o = '0;
    busy_o      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bram_en_o   = 1'b1;
        bram_addr_o = base_q + ADDR_W'(cnt_q);
        busy_o      = 1'b1;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign issue        = (state_q == S_FETCH);
  assign issue_first  = issue && (cnt_q == '0);
  assign issue_last   = issue && (cnt_q == LAST_K);
  assign start_reject = start_i && (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // Read-latency tag pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0]   <= issue;
      first_pipe_q[0] <= issue_first;
      last_pipe_q[0]  <= issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]   <= vld_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
        last_pipe_q[i]  <= last_pipe_q[i-1];
      end
    end
  end

  assign bram_vld = vld_pipe_q[RD_LATENCY-1];

  // -------------------------------------------------------------------------
  // Output register: expansion and overrun reporting
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      intensity_q  <= '0;
      phase_q      <= '0;
      overrun_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      dout_valid_q <= bram_vld;
      dout_first_q <= first_pipe_q[RD_LATENCY-1];
      dout_last_q  <= last_pipe_q[RD_LATENCY-1];
      // Byte replication maps 0xFF to full scale 0xFFFF exactly.
      intensity_q  <= (bram_vld && !fz_q) ? {bram_dout_i[7:0], bram_dout_i[7:0]} : 16'h0000;
      phase_q      <= bram_vld ? {bram_dout_i[15:8], 8'h00} : 16'h0000;
      overrun_q    <= start_reject;
      sticky_q     <= sticky_q | start_reject;
    end
  end

  assign dout_valid_o     = dout_valid_q;
  assign dout_first_o     = dout_first_q;
  assign intensity_out_o  = intensity_q;
  assign phase_out_o      = phase_q;
  assign overrun_o        = overrun_q;
  assign overrun_sticky_o = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_drive_frame_streamer.sv
// ============================================================================
//  Module      : tb_drive_frame_streamer
//  Description : Self-checking bench; three DUT lanes (read latency 1, 2, 4)
//                share stimulus and are compared every cycle to a frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drive_frame_streamer;

  localparam int DEPTH  = 249;
  localparam int ADDR_W = 14;
  localparam int NLANE  = 3;
  localparam int MSIZE  = 1 << ADDR_W;

  logic clk;
  logic rst;
  logic start;
  logic [ADDR_W-1:0] base;
  logic fz;

  logic [NLANE-1:0]  bram_en;
  logic [ADDR_W-1:0] bram_addr [NLANE];
  logic [15:0]       bram_dout [NLANE];
  logic [NLANE-1:0]  dv;
  logic [NLANE-1:0]  df;
  logic [15:0]       int_o [NLANE];
  logic [15:0]       ph_o  [NLANE];
  logic [NLANE-1:0]  busy;
  logic [NLANE-1:0]  ovr;
  logic [NLANE-1:0]  sticky;

  logic [15:0] mem [0:MSIZE-1];
  int ecnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [ADDR_W-1:0] apipe [LAT];
    logic [LAT-1:0]    vpipe;

    // BRAM with LAT cycles from address to data; garbage when no read is due.
    always @(posedge clk) begin
      apipe[0] <= bram_addr[g];
      vpipe[0] <= bram_en[g];
      for (int i = 1; i < LAT; i++) begin
        apipe[i] <= apipe[i-1];
        vpipe[i] <= vpipe[i-1];
      end
    end
    assign bram_dout[g] = vpipe[LAT-1] ? mem[apipe[LAT-1]] : 16'hDEAD;

    drive_frame_streamer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LATENCY(LAT)
    ) u_dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .base_addr_i     (base),
      .force_zero_i    (fz),
      .bram_en_o       (bram_en[g]),
      .bram_addr_o     (bram_addr[g]),
      .bram_dout_i     (bram_dout[g]),
      .dout_valid_o    (dv[g]),
      .dout_first_o    (df[g]),
      .intensity_out_o (int_o[g]),
      .phase_out_o     (ph_o[g]),
      .busy_o          (busy[g]),
      .overrun_o       (ovr[g]),
      .overrun_sticky_o(sticky[g])
    );
  end

  // Frame model: one accepted frame per lane, everything derived from its
  // start edge, base address and force-zero flag.
  bit m_live   [NLANE];
  int m_e0     [NLANE];
  int m_base   [NLANE];
  bit m_fz     [NLANE];
  int m_ovr    [NLANE];
  bit m_sticky [NLANE];

  int          cap_n   [NLANE];
  logic [15:0] cap_int [NLANE];
  logic [15:0] cap_ph  [NLANE];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] word;
    logic        fz;
    logic [15:0] exp_int;
    logic [15:0] exp_ph;
  } vec_t;
  vec_t tbl [7];

  function automatic int lat(int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 4;
  endfunction

  function automatic bit busy_model(int l, int c);
    return m_live[l] && (c >= m_e0[l] + 1) && (c <= m_e0[l] + lat(l) + 1 + DEPTH);
  endfunction

  function automatic logic [51:0] expect_out(int l, int c);
    logic              en, v, f;
    logic [ADDR_W-1:0] a;
    logic [15:0]       w, iv, pv;
    int                k;
    en = 1'b0; v = 1'b0; f = 1'b0; a = '0; iv = '0; pv = '0; w = '0;
    if (m_live[l]) begin
      k = c - m_e0[l] - 1;
      if (k >= 0 && k < DEPTH) begin
        en = 1'b1;
        a  = ADDR_W'((m_base[l] + k) % MSIZE);
      end
      k = c - m_e0[l] - lat(l) - 2;
      if (k >= 0 && k < DEPTH) begin
        v  = 1'b1;
        f  = (k == 0);
        w  = mem[(m_base[l] + k) % MSIZE];
        iv = m_fz[l] ? 16'h0000 : {w[7:0], w[7:0]};
        pv = {w[15:8], 8'h00};
      end
    end
    return {en, a, v, f, iv, pv, busy_model(l, c), (m_ovr[l] == c), m_sticky[l]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: compare the current cycle's outputs, then let the model see
  // the inputs that this cycle's closing edge samples.
  task automatic tick(input bit s, input int b, input bit f, input bit r);
    int          e;
    logic [51:0] act;
    start = s;
    base  = ADDR_W'(b);
    fz    = f;
    rst   = r;
    e     = ecnt + 1;
    for (int l = 0; l < NLANE; l++) begin
      act = {bram_en[l], bram_addr[l], dv[l], df[l], int_o[l], ph_o[l], busy[l], ovr[l], sticky[l]};
      chk($sformatf("cycle lane%0d c=%0d", l, e), 64'(act), 64'(expect_out(l, e)));
      if (dv[l] === 1'b1) begin
        cap_n[l]++;
        cap_int[l] = int_o[l];
        cap_ph[l]  = ph_o[l];
      end
      if (r) begin
        m_live[l]   = 1'b0;
        m_sticky[l] = 1'b0;
        m_ovr[l]    = -1;
        cap_n[l]    = 0;
      end else if (s) begin
        if (busy_model(l, e)) begin
          m_ovr[l]    = e + 1;
          m_sticky[l] = 1'b1;
        end else begin
          m_live[l] = 1'b1;
          m_e0[l]   = e;
          m_base[l] = b & (MSIZE - 1);
          m_fz[l]   = f;
          cap_n[l]  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, int'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic chk_counts(input string tag);
    for (int l = 0; l < NLANE; l++) chk($sformatf("%s count lane%0d", tag, l), 64'(cap_n[l]), 64'(DEPTH));
  endtask

  initial begin
    tbl[0] = '{16'hFF00, 1'b0, 16'h0000, 16'hFF00};
    tbl[1] = '{16'h00FF, 1'b0, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'hFF00, 1'b1, 16'h0000, 16'hFF00};
    tbl[3] = '{16'h00FF, 1'b1, 16'h0000, 16'h0000};
    tbl[4] = '{16'h5AA5, 1'b0, 16'hA5A5, 16'h5A00};
    tbl[5] = '{16'h5AA5, 1'b1, 16'h0000, 16'h5A00};
    tbl[6] = '{16'h0180, 1'b0, 16'h8080, 16'h0100};

    for (int l = 0; l < NLANE; l++) begin
      m_live[l] = 1'b0; m_e0[l] = 0; m_base[l] = 0; m_fz[l] = 1'b0;
      m_ovr[l] = -1; m_sticky[l] = 1'b0; cap_n[l] = 0;
      cap_int[l] = '0; cap_ph[l] = '0;
    end
    for (int a = 0; a < MSIZE; a++) mem[a] = 16'(a);

    rst = 1'b1; start = 1'b0; base = '0; fz = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, then basic frame
    idle(4);
    tick(1'b1, 'h100, 1'b0, 1'b0);
    idle(270);
    chk_counts("basic");

    // Address wrap: last sample comes from address 0x00E8
    tick(1'b1, 'h3FF0, 1'b0, 1'b0);
    idle(270);
    chk_counts("wrap");
    for (int l = 0; l < NLANE; l++)
      chk($sformatf("wrap last lane%0d", l), 64'({cap_int[l], cap_ph[l]}), 64'({16'hE8E8, 16'h0000}));

    // Overrun 50 cycles into a frame: no second burst, sticky latched
    tick(1'b1, 'h200, 1'b0, 1'b0);
    idle(49);
    tick(1'b1, 'h800, 1'b1, 1'b0);
    idle(270);
    chk_counts("overrun");
    for (int l = 0; l < NLANE; l++)
      chk($sformatf("sticky lane%0d", l), 64'(sticky[l]), 64'(1));

    // START in the first BUSY-low cycle of each lane
    for (int l = 0; l < NLANE; l++) begin
      tick(1'b1, 'h40, 1'b0, 1'b0);
      idle(lat(l) + 1 + DEPTH);
      chk($sformatf("b2b busy-low lane%0d", l), 64'(busy[l]), 64'(0));
      tick(1'b1, 'h1000, 1'b1, 1'b0);
      idle(270);
      chk($sformatf("b2b count lane%0d", l), 64'(cap_n[l]), 64'(DEPTH));
    end

    // START held for three cycles
    tick(1'b1, 'h1234, 1'b0, 1'b0);
    tick(1'b1, 'h0000, 1'b1, 1'b0);
    tick(1'b1, 'h0000, 1'b1, 1'b0);
    idle(270);
    chk_counts("held");

    // Reset 100 cycles into a frame, then a clean frame
    tick(1'b1, 'h300, 1'b0, 1'b0);
    idle(99);
    tick(1'b0, 'h300, 1'b0, 1'b1);
    idle(20);
    for (int l = 0; l < NLANE; l++)
      chk($sformatf("post-reset lane%0d", l), 64'({dv[l], bram_en[l], busy[l], sticky[l]}), 64'(0));
    tick(1'b1, 'h300, 1'b0, 1'b0);
    idle(270);
    chk_counts("after-reset");

    // Expansion table
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < DEPTH; k++) mem['h2000 + k] = tbl[t].word;
      tick(1'b1, 'h2000, tbl[t].fz, 1'b0);
      idle(265);
      for (int l = 0; l < NLANE; l++)
        chk($sformatf("tbl%0d lane%0d", t, l), 64'({cap_int[l], cap_ph[l]}),
            64'({tbl[t].exp_int, tbl[t].exp_ph}));
    end

    // Randomized traffic
    for (int a = 0; a < MSIZE; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 5000; i++)
      tick($urandom_range(0, 99) < 2, int'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 999) < 2);
    idle(270);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
